// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int STAT_W     = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hazardState_t;

  // Observation bundle: FSM state plus the per-cycle event strobes.
  typedef struct packed {
    hazardState_t state;
    hazardState_t retState;
    logic [2:0]   stallCnt;
    logic [7:0]   waitCnt;
    logic         depPending;
    logic         loadEvt;
    logic         flushEvt;
  } hazardDbg_t;

  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_addr_match.sv
// Register-address hazard compare: equal and not $zero.
module hazard_addr_match
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] a,
  input  logic [REG_ADDR_W-1:0] b,
  output logic                  match
);

  assign match = (a == b) && (a != ZERO_REG);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline advance/hold/squash controller (load-use, taken branch, slow dmem).
// Optional performance counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_write,
  output logic                  exmem_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_error,
  output logic [STAT_W-1:0]     stat_load_stalls,
  output logic [STAT_W-1:0]     stat_mem_waits,
  output logic [STAT_W-1:0]     stat_flushes,
  output hazardDbg_t            dbg
);

  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX     = 8'(MEM_TIMEOUT);

  hazardState_t          state, stateNext, retState, retStateNext, effState;
  logic [2:0]            stallCnt, stallCntNext;
  logic [7:0]            waitCnt, waitCntNext;
  logic [REG_ADDR_W-1:0] loadRd, loadRdNext;
  logic                  rsMatch, rtMatch, depMatch;
  logic                  memStall, loadUse, loadDetect, branchFlush;

  hazard_addr_match uRsMatch  (.a(ex_rt),  .b(id_rs), .match(rsMatch));
  hazard_addr_match uRtMatch  (.a(ex_rt),  .b(id_rt), .match(rtMatch));
  hazard_addr_match uDepMatch (.a(loadRd), .b(id_rs), .match(depMatch));

  assign memStall = mem_req && !mem_ready;
  assign loadUse  = ex_mem_read && (rsMatch || (id_uses_rt && rtMatch));

  always_comb begin
    stateNext    = state;
    retStateNext = retState;
    stallCntNext = stallCnt;
    waitCntNext  = '0;
    loadRdNext   = loadRd;
    loadDetect   = 1'b0;
    branchFlush  = 1'b0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    // A released wait cycle behaves exactly like the state it interrupted.
    effState = (state == MEM_WAIT) ? retState : state;

    if (memStall) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      stateNext = MEM_WAIT;
      if (state != MEM_WAIT) retStateNext = state;
      waitCntNext = (waitCnt == WAIT_MAX) ? waitCnt : waitCnt + 8'd1;
    end else if (ex_branch_taken) begin
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      stallCntNext = '0;
      stateNext    = RUN;
      branchFlush  = 1'b1;
    end else if (effState == LOAD_STALL) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
      stallCntNext = stallCnt - 3'd1;
      stateNext    = (stallCnt <= 3'd1) ? RUN : LOAD_STALL;
    end else if (loadUse) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      loadDetect = 1'b1;
      stateNext  = RUN;
      if (LOAD_STALL_CYCLES > 1) begin
        loadRdNext   = ex_rt;
        stallCntNext = STALL_RELOAD;
        stateNext    = LOAD_STALL;
      end
    end else begin
      stateNext = RUN;
    end

    if (reset) begin
      {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      retState  <= RUN;
      stallCnt  <= '0;
      waitCnt   <= '0;
      loadRd    <= ZERO_REG;
      mem_error <= 1'b0;
    end else begin
      state    <= stateNext;
      retState <= retStateNext;
      stallCnt <= stallCntNext;
      waitCnt  <= waitCntNext;
      loadRd   <= loadRdNext;
      if (memStall && (waitCntNext == WAIT_MAX)) mem_error <= 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] statLoad, statWait, statFlush;

  always_ff @(posedge clk) begin
    if (reset) begin
      statLoad  <= '0;
      statWait  <= '0;
      statFlush <= '0;
    end else begin
      if (loadDetect)  statLoad  <= satInc(statLoad);
      if (memStall)    statWait  <= satInc(statWait);
      if (branchFlush) statFlush <= satInc(statFlush);
    end
  end

  assign stat_load_stalls = statLoad;
  assign stat_mem_waits   = statWait;
  assign stat_flushes     = statFlush;
`else
  assign stat_load_stalls = '0;
  assign stat_mem_waits   = '0;
  assign stat_flushes     = '0;
`endif

  assign dbg.state      = state;
  assign dbg.retState   = retState;
  assign dbg.stallCnt   = stallCnt;
  assign dbg.waitCnt    = waitCnt;
  assign dbg.depPending = depMatch;
  assign dbg.loadEvt    = loadDetect;
  assign dbg.flushEvt   = branchFlush;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two configurations driven in parallel
// against a cycle-level model of the stall/flush rules.
module tb_hazard_stall_controller;
  import hazard_pkg::*;

`ifdef HAZARD_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_req, mem_ready;

  logic [1:0]  pcW, ifW, ixW, emW, ifF, ixF, memErr;
  logic [31:0] sLd[2], sWt[2], sFl[2];
  hazardDbg_t  dbg[2];
  logic [5:0]  ctl[2];

  hazard_stall_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) dutA (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcW[0]), .ifid_write(ifW[0]),
    .idex_write(ixW[0]), .exmem_write(emW[0]), .ifid_flush(ifF[0]), .idex_flush(ixF[0]),
    .mem_error(memErr[0]), .stat_load_stalls(sLd[0]), .stat_mem_waits(sWt[0]),
    .stat_flushes(sFl[0]), .dbg(dbg[0]));

  hazard_stall_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) dutB (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pcW[1]), .ifid_write(ifW[1]),
    .idex_write(ixW[1]), .exmem_write(emW[1]), .ifid_flush(ifF[1]), .idex_flush(ixF[1]),
    .mem_error(memErr[1]), .stat_load_stalls(sLd[1]), .stat_mem_waits(sWt[1]),
    .stat_flushes(sFl[1]), .dbg(dbg[1]));

  // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush}
  always_comb
    for (int i = 0; i < 2; i++) ctl[i] = {pcW[i], ifW[i], ixW[i], emW[i], ifF[i], ixF[i]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s dut%0d actual=%h expected=%h at %0t", name, d, act, exp, $time);
    end
  endtask

  // reference model: remaining bubbles, frozen-run length, sticky error, event counts
  int          lsc[2] = '{1, 3};
  int          mto[2] = '{255, 8};
  int          pend[2] = '{0, 0};
  int          waitRun[2] = '{0, 0};
  bit          errM[2] = '{0, 0};
  logic [31:0] stM[2][3];
  initial for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) stM[i][k] = '0;

  function automatic bit hz(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd0);
  endfunction

  function automatic bit loadUseNow();
    return ex_mem_read && (hz(ex_rt, id_rs) || (id_uses_rt && hz(ex_rt, id_rt)));
  endfunction

  function automatic logic [5:0] expCtl(input int i);
    if (reset) return 6'b000011;
    if (mem_req && !mem_ready) return 6'b000000;
    if (ex_branch_taken) return 6'b111111;
    if (pend[i] > 0 || loadUseNow()) return 6'b001101;
    return 6'b111100;
  endfunction

  task automatic modelStep(input int i);
    if (reset) begin
      pend[i] = 0; waitRun[i] = 0; errM[i] = 0;
      for (int k = 0; k < 3; k++) stM[i][k] = '0;
    end else if (mem_req && !mem_ready) begin
      waitRun[i] = (waitRun[i] + 1 > mto[i]) ? mto[i] : waitRun[i] + 1;
      if (waitRun[i] == mto[i]) errM[i] = 1;
      stM[i][1] = stM[i][1] + 1;
    end else begin
      waitRun[i] = 0;
      if (ex_branch_taken) begin
        pend[i] = 0;
        stM[i][2] = stM[i][2] + 1;
      end else if (pend[i] > 0) begin
        pend[i] = pend[i] - 1;
      end else if (loadUseNow()) begin
        pend[i] = lsc[i] - 1;
        stM[i][0] = stM[i][0] + 1;
      end
    end
  endtask

  // scoreboard: compare every cycle, then advance the model across the next edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("ctl", i, 32'(ctl[i]), 32'(expCtl(i)));
      chk("mem_error", i, 32'(memErr[i]), 32'(errM[i]));
      chk("stat_load_stalls", i, sLd[i], STATS_ON ? stM[i][0] : 32'd0);
      chk("stat_mem_waits", i, sWt[i], STATS_ON ? stM[i][1] : 32'd0);
      chk("stat_flushes", i, sFl[i], STATS_ON ? stM[i][2] : 32'd0);
      modelStep(i);
    end
  end

  // driver tasks
  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  int cntA, cntB;

  initial begin
    setIdle();
    reset = 1'b1;
    nextCyc(); nextCyc();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", i, 32'(ctl[i]), 32'b000011);
      chk("rst_err", i, 32'(memErr[i]), 32'd0);
    end
    nextCyc();
    reset = 1'b0;

    // lw $2 in EX, add rs=$2 in ID
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
    @(negedge clk);
    chk("lu_stall", 0, 32'(ctl[0]), 32'b001101);
    chk("lu_stall", 1, 32'(ctl[1]), 32'b001101);
    nextCyc(); setIdle();
    @(negedge clk);
    chk("lu_release", 0, 32'(ctl[0]), 32'b111100);
    chk("lu_hold", 1, 32'(ctl[1]), 32'b001101);
    nextCyc();
    @(negedge clk);
    chk("lu_hold2", 1, 32'(ctl[1]), 32'b001101);
    nextCyc();
    @(negedge clk);
    chk("lu_release", 1, 32'(ctl[1]), 32'b111100);
    chk("lu_stat", 0, sLd[0], STATS_ON ? 32'd1 : 32'd0);
    chk("lu_stat", 1, sLd[1], STATS_ON ? 32'd1 : 32'd0);
    nextCyc();

    // $zero never hazards
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    @(negedge clk);
    chk("zero_reg", 0, 32'(ctl[0]), 32'b111100);
    chk("zero_reg", 1, 32'(ctl[1]), 32'b111100);
    nextCyc();

    // rt hazard: 3 held cycles at LOAD_STALL_CYCLES=3, 1 at LOAD_STALL_CYCLES=1
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b1;
    cntA = 0; cntB = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (pcW[0] == 1'b0) cntA++;
      if (pcW[1] == 1'b0) cntB++;
      nextCyc();
      setIdle();
    end
    chk("rt_stall_len", 0, 32'(cntA), 32'd1);
    chk("rt_stall_len", 1, 32'(cntB), 32'd3);
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
    @(negedge clk);
    chk("rt_unused", 0, 32'(ctl[0]), 32'b111100);
    chk("rt_unused", 1, 32'(ctl[1]), 32'b111100);
    nextCyc(); setIdle();

    // 4 frozen cycles, released on the 5th
    reset = 1'b1; nextCyc(); reset = 1'b0;
    mem_req = 1'b1; mem_ready = 1'b0;
    cntA = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ctl[0][5:2] == 4'b0000) cntA++;
      nextCyc();
    end
    chk("wait_frozen", 0, 32'(cntA), 32'd4);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wait_release", 0, 32'(ctl[0]), 32'b111100);
    nextCyc(); setIdle();
    @(negedge clk);
    chk("wait_stat", 0, sWt[0], STATS_ON ? 32'd4 : 32'd0);
    nextCyc();

    // taken branch while stall_cnt=2 cancels the stall
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
    nextCyc(); setIdle(); ex_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_in_stall", 1, 32'(ctl[1]), 32'b111111);
    nextCyc(); setIdle();
    @(negedge clk);
    chk("br_state", 1, 32'(dbg[1].state), 32'(RUN));
    chk("br_after", 1, 32'(ctl[1]), 32'b111100);
    nextCyc();

    // timeout at MEM_TIMEOUT=8, sticky, cleared by reset
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) chk("tmo_before", 1, 32'(memErr[1]), 32'd0);
      if (k == 9) chk("tmo_set", 1, 32'(memErr[1]), 32'd1);
      nextCyc();
    end
    setIdle(); nextCyc();
    @(negedge clk);
    chk("tmo_sticky", 1, 32'(memErr[1]), 32'd1);
    nextCyc();
    reset = 1'b1;
    @(negedge clk);
    chk("tmo_rst_ctl", 1, 32'(ctl[1]), 32'b000011);
    nextCyc();
    @(negedge clk);
    chk("tmo_rst_err", 1, 32'(memErr[1]), 32'd0);
    nextCyc();
    reset = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 9) < 4);
      reset           = ($urandom_range(0, 199) == 0);
      nextCyc();
    end
    reset = 1'b0; setIdle();
    nextCyc();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
